// File: rtl/scr1_vlsu_pkg.sv
// Shared types for the vector load/store sequencer: lane geometry, FSM states,
// command and data-memory response encodings.
package scr1_vlsu_pkg;

    localparam int LANE = 4;
    localparam int XLEN = 32;

    typedef logic [LANE-1:0][XLEN-1:0] type_vector;

    typedef enum logic [2:0] {
        VLSU_IDLE,
        VLSU_REQ,
        VLSU_RESP,
        VLSU_WB,
        VLSU_ERR,
        VLSU_DONE
    } type_scr1_vlsu_fsm_e;

    typedef enum logic {
        VLSU_CMD_LOAD  = 1'b0,
        VLSU_CMD_STORE = 1'b1
    } type_scr1_vlsu_cmd_e;

    localparam logic [1:0] DMEM_RESP_NOTRDY = 2'b00;
    localparam logic [1:0] DMEM_RESP_RDY    = 2'b01;
    localparam logic [1:0] DMEM_RESP_ER     = 2'b10;

endpackage

// File: rtl/scr1_vlsu_agen.sv
// Lane address generator: loads base/stride on accept, steps by stride per
// completed lane (wrapping modulo 2^XLEN), flags misaligned base or stride.
module scr1_vlsu_agen
    import scr1_vlsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] stride,
    input  logic            advance,
    output logic [XLEN-1:0] addr,
    output logic            misaligned
);

    logic [XLEN-1:0] stride_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            stride_q <= '0;
        end else if (load) begin
            addr     <= base;
            stride_q <= stride;
        end else if (advance) begin
            addr     <= addr + stride_q;
        end
    end

    // Word accesses only; a misaligned stride would misalign every later lane.
    assign misaligned = (base[1:0] != 2'b00) || (stride[1:0] != 2'b00);

endmodule

// File: rtl/scr1_pipe_vlsu.sv
// Vector load/store sequencer: one operation in flight, issues LANE word
// accesses to data memory and writes assembled load vectors to the MPRF.
module scr1_pipe_vlsu
    import scr1_vlsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exu2vlsu_req,
    input  logic            exu2vlsu_cmd,
    input  logic [XLEN-1:0] exu2vlsu_base,
    input  logic [XLEN-1:0] exu2vlsu_stride,
    input  logic [4:0]      exu2vlsu_rd_addr,
    input  type_vector      exu2vlsu_sdata,
    output logic            vlsu2exu_ready,
    output logic            vlsu2exu_done,
    output logic            vlsu2exu_err,
    output logic            vlsu2dmem_req,
    output logic            vlsu2dmem_cmd,
    output logic [XLEN-1:0] vlsu2dmem_addr,
    output logic [XLEN-1:0] vlsu2dmem_wdata,
    input  logic            dmem2vlsu_req_ack,
    input  logic [1:0]      dmem2vlsu_resp,
    input  logic [XLEN-1:0] dmem2vlsu_rdata,
    output logic            vlsu2mprf_w_req,
    output logic [4:0]      vlsu2mprf_rd_addr,
    output logic            vlsu2mprf_rd_vec,
    output type_vector      vlsu2mprf_rd_data
);

    localparam int IW = (LANE > 1) ? $clog2(LANE) : 1;

    type_scr1_vlsu_fsm_e state, state_next;
    type_scr1_vlsu_cmd_e cmd_q;
    logic [4:0]          rd_addr_q;
    type_vector          sdata_q;
    type_vector          buf_q;
    logic [IW-1:0]       lane_idx;
    logic                err_q;
    logic                misaligned;
    logic                accept;
    logic                resp_rdy;
    logic                resp_err;
    logic                lane_last;

    assign accept    = exu2vlsu_req && (state == VLSU_IDLE);
    assign resp_rdy  = (state == VLSU_RESP) && (dmem2vlsu_resp == DMEM_RESP_RDY);
    assign resp_err  = (state == VLSU_RESP) && (dmem2vlsu_resp == DMEM_RESP_ER);
    assign lane_last = (lane_idx == IW'(LANE - 1));

    scr1_vlsu_agen i_agen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .base       (exu2vlsu_base),
        .stride     (exu2vlsu_stride),
        .advance    (resp_rdy),
        .addr       (vlsu2dmem_addr),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= VLSU_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            VLSU_IDLE: if (exu2vlsu_req) state_next = misaligned ? VLSU_ERR : VLSU_REQ;
            VLSU_REQ:  if (dmem2vlsu_req_ack) state_next = VLSU_RESP;
            VLSU_RESP: begin
                if (resp_rdy) begin
                    if (!lane_last)                   state_next = VLSU_REQ;
                    else if (cmd_q == VLSU_CMD_STORE) state_next = VLSU_DONE;
                    else                              state_next = VLSU_WB;
                end else if (resp_err) begin
                    state_next = VLSU_ERR;
                end
            end
            VLSU_WB:   state_next = VLSU_DONE;
            VLSU_ERR:  state_next = VLSU_DONE;
            VLSU_DONE: state_next = VLSU_IDLE;
            default:   state_next = VLSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= VLSU_CMD_LOAD;
            rd_addr_q <= '0;
            sdata_q   <= '0;
            lane_idx  <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            cmd_q     <= type_scr1_vlsu_cmd_e'(exu2vlsu_cmd);
            rd_addr_q <= exu2vlsu_rd_addr;
            sdata_q   <= exu2vlsu_sdata;
            lane_idx  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (resp_rdy)            lane_idx <= lane_idx + 1'b1;
            if (state == VLSU_ERR)   err_q    <= 1'b1;
        end
    end

    // Lanes not reached by the current load keep stale data; WB is only
    // entered after the last lane, so stale lanes are never written out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (resp_rdy && (cmd_q == VLSU_CMD_LOAD)) begin
            buf_q[lane_idx] <= dmem2vlsu_rdata;
        end
    end

    assign vlsu2exu_ready    = (state == VLSU_IDLE);
    assign vlsu2exu_done     = (state == VLSU_DONE);
    assign vlsu2exu_err      = (state == VLSU_DONE) && err_q;
    assign vlsu2dmem_req     = (state == VLSU_REQ);
    assign vlsu2dmem_cmd     = cmd_q;
    assign vlsu2dmem_wdata   = sdata_q[lane_idx];
    assign vlsu2mprf_w_req   = (state == VLSU_WB);
    assign vlsu2mprf_rd_addr = rd_addr_q;
    assign vlsu2mprf_rd_vec  = 1'b1;
    assign vlsu2mprf_rd_data = buf_q;

endmodule

// File: tb/tb_scr1_pipe_vlsu.sv
// Directed bench for scr1_pipe_vlsu: responder memory (mem[a]=a) with
// configurable ack stall and error lane, scoreboard of memory/MPRF/done events.
module tb_scr1_pipe_vlsu;
    import scr1_vlsu_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            exu_req = 1'b0;
    logic            exu_cmd = 1'b0;
    logic [31:0]     exu_base = '0;
    logic [31:0]     exu_stride = '0;
    logic [4:0]      exu_rd = '0;
    type_vector      exu_sdata = '0;
    logic            ready, done, err;
    logic            dmem_req, dmem_cmd;
    logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
    logic            dmem_ack;
    logic [1:0]      dmem_resp;
    logic            w_req, rd_vec;
    logic [4:0]      rd_addr;
    type_vector      rd_data;

    always #5 clk = ~clk;

    scr1_pipe_vlsu dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .exu2vlsu_req      (exu_req),
        .exu2vlsu_cmd      (exu_cmd),
        .exu2vlsu_base     (exu_base),
        .exu2vlsu_stride   (exu_stride),
        .exu2vlsu_rd_addr  (exu_rd),
        .exu2vlsu_sdata    (exu_sdata),
        .vlsu2exu_ready    (ready),
        .vlsu2exu_done     (done),
        .vlsu2exu_err      (err),
        .vlsu2dmem_req     (dmem_req),
        .vlsu2dmem_cmd     (dmem_cmd),
        .vlsu2dmem_addr    (dmem_addr),
        .vlsu2dmem_wdata   (dmem_wdata),
        .dmem2vlsu_req_ack (dmem_ack),
        .dmem2vlsu_resp    (dmem_resp),
        .dmem2vlsu_rdata   (dmem_rdata),
        .vlsu2mprf_w_req   (w_req),
        .vlsu2mprf_rd_addr (rd_addr),
        .vlsu2mprf_rd_vec  (rd_vec),
        .vlsu2mprf_rd_data (rd_data)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int          ack_delay = 0;
    int          err_at = -1;
    int          op_hs0 = 0;
    int          hs_cnt = 0;
    int          wait_cnt = 0;
    int          cyc = 0;
    logic        pend, pend_err;
    logic [31:0] pend_data;

    assign dmem_ack   = dmem_req && (wait_cnt >= ack_delay);
    assign dmem_resp  = pend ? (pend_err ? 2'b10 : 2'b01) : 2'b00;
    assign dmem_rdata = pend ? pend_data : 32'hDEAD_BEEF;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_err  <= 1'b0;
            pend_data <= '0;
            wait_cnt  <= 0;
        end else begin
            pend      <= dmem_req && dmem_ack;
            pend_err  <= ((hs_cnt - op_hs0) == err_at);
            pend_data <= dmem_addr;
            if (dmem_req && dmem_ack) begin
                hs_cnt   <= hs_cnt + 1;
                wait_cnt <= 0;
            end else if (dmem_req) begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [31:0] addr; logic cmd; logic [31:0] wdata; } mem_txn_t;
    typedef struct packed { logic [4:0] rd; type_vector data; } mprf_txn_t;
    mem_txn_t  mem_q[$];
    mprf_txn_t mprf_q[$];
    bit        done_q[$];

    logic        stall_prev = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;

    always @(negedge clk) begin
        mem_txn_t  mt;
        mprf_txn_t pt;
        bit        de;
        if (rst_n) begin
            if (dmem_req && stall_prev) begin
                chk("stall_addr_stable", dmem_addr, prev_addr);
                chk("stall_wdata_stable", dmem_wdata, prev_wdata);
            end
            if (dmem_req && dmem_ack) begin
                chk("mem_expected", mem_q.size() != 0, 1);
                if (mem_q.size() != 0) begin
                    mt = mem_q.pop_front();
                    chk("mem_addr", dmem_addr, mt.addr);
                    chk("mem_cmd", dmem_cmd, mt.cmd);
                    if (mt.cmd) chk("mem_wdata", dmem_wdata, mt.wdata);
                end
            end
            if (w_req) begin
                chk("mprf_expected", mprf_q.size() != 0, 1);
                if (mprf_q.size() != 0) begin
                    pt = mprf_q.pop_front();
                    chk("mprf_rd_addr", rd_addr, pt.rd);
                    chk("mprf_data", rd_data, pt.data);
                    chk("mprf_rd_vec", rd_vec, 1);
                end
            end
            if (done) begin
                chk("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    de = done_q.pop_front();
                    chk("done_err", err, de);
                end
            end
        end
        stall_prev <= rst_n && dmem_req && !dmem_ack;
        prev_addr  <= dmem_addr;
        prev_wdata <= dmem_wdata;
    end

    // Pushes expectations, issues one request; optionally waits for done and
    // returns edges from the accepting edge to the done cycle.
    task automatic run_op(input logic cmd, input logic [31:0] base, input logic [31:0] stride,
                          input logic [4:0] rd, input type_vector sd, input int e_at,
                          input int adly, input bit wait_done, output int edges);
        bit         mis;
        mem_txn_t   mt;
        mprf_txn_t  pt;
        int         c0;
        ack_delay = adly;
        err_at    = e_at;
        op_hs0    = hs_cnt;
        mis = (base[1:0] != 2'b00) || (stride[1:0] != 2'b00);
        pt.rd   = rd;
        pt.data = '0;
        if (!mis) begin
            for (int i = 0; i < LANE; i++) begin
                if (e_at >= 0 && i > e_at) break;
                mt.addr  = base + 32'(i) * stride;
                mt.cmd   = cmd;
                mt.wdata = sd[i];
                pt.data[i] = mt.addr;
                mem_q.push_back(mt);
            end
        end
        if (!mis && !cmd && e_at < 0) mprf_q.push_back(pt);
        done_q.push_back(mis || (e_at >= 0));
        chk("ready_before_req", ready, 1);
        exu_req = 1'b1; exu_cmd = cmd; exu_base = base; exu_stride = stride;
        exu_rd = rd; exu_sdata = sd;
        c0 = cyc;
        @(negedge clk);
        exu_req = 1'b0;
        edges = -1;
        if (wait_done) begin
            for (int k = 0; k < 300 && !done; k++) @(negedge clk);
            chk("done_seen", done, 1);
            edges = cyc - c0;
            @(negedge clk);
            chk("ready_after_done", ready, 1);
            chk("mem_q_drained", mem_q.size(), 0);
            chk("mprf_q_drained", mprf_q.size(), 0);
            chk("done_q_drained", done_q.size(), 0);
        end
    endtask

    initial begin
        int          edges;
        int          hs_before;
        type_vector  sd;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_rd_vec", rd_vec, 1);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_w_req", w_req, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: plain load, zero-wait, latency 2*LANE+3 including accept cycle
        run_op(1'b0, 32'h100, 32'h4, 5'd3, '0, -1, 0, 1'b1, edges);
        chk("t1_latency", edges + 1, 2 * LANE + 3);

        // 2: negative stride wrapping through zero, rd_addr=0 still written
        run_op(1'b0, 32'h4, 32'hFFFF_FFF8, 5'd0, '0, -1, 0, 1'b1, edges);

        // 3: store with 3-cycle ack stall per lane
        sd = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        run_op(1'b1, 32'h200, 32'h10, 5'd7, sd, -1, 3, 1'b1, edges);

        // 4: bus error on lane 2 of a load
        run_op(1'b0, 32'h300, 32'h4, 5'd9, '0, 2, 0, 1'b1, edges);

        // 5: misaligned base, no memory traffic
        hs_before = hs_cnt;
        run_op(1'b0, 32'h102, 32'h4, 5'd1, '0, -1, 0, 1'b1, edges);
        chk("t5_done_after_accept", edges, 2);
        chk("t5_no_dmem", hs_cnt, hs_before);

        // 6: reset in RESP of lane 1 abandons the load
        run_op(1'b0, 32'h400, 32'h4, 5'd5, '0, -1, 0, 1'b0, edges);
        for (int k = 0; k < 50 && (hs_cnt - op_hs0) < 2; k++) @(negedge clk);
        chk("t6_reached_lane1", hs_cnt - op_hs0, 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", ready, 1);
        chk("t6_rst_dmem_req", dmem_req, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_w_req", w_req, 0);
        chk("t6_rst_rd_data", rd_data, 0);
        chk("t6_rst_addr", dmem_addr, 0);
        chk("t6_lanes_left", mem_q.size(), LANE - 2);
        mem_q.delete();
        mprf_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'h500, 32'h20, 5'd31, '0, -1, 0, 1'b1, edges);
        chk("t6_post_latency", edges + 1, 2 * LANE + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

endmodule
